// File: rtl/plugin_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : plugin_collector_pkg
// Brief    : Shared state encoding, default sizes and helpers for plugin blocks
// Revision : 1.0
// ============================================================================
package plugin_collector_pkg;

    localparam int c_def_num_plugins    = 4;
    localparam int c_def_warp_width     = 16;
    localparam int c_def_error_width    = 32;
    localparam int c_def_timeout_cycles = 64;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_start   = 3'd1;
    localparam logic [2:0] c_st_collect = 3'd2;
    localparam logic [2:0] c_st_select  = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

    // Slot index width; a single-slot build still needs a 1-bit id.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/plugin_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : plugin_collector_if
// Brief    : Request/plugin/result bundle between the collector and its users
// Revision : 1.0
// ============================================================================
interface plugin_collector_if import plugin_collector_pkg::*; #(
    parameter int NUM_PLUGINS = c_def_num_plugins,
    parameter int WARP_WIDTH  = c_def_warp_width,
    parameter int ERROR_WIDTH = c_def_error_width
) ();
    localparam int SEL_W = sel_width(NUM_PLUGINS);

    logic                              req;
    logic                              busy;
    logic                              plugin_start;
    logic [NUM_PLUGINS-1:0]            plugin_valid;
    logic [NUM_PLUGINS*WARP_WIDTH-1:0] plugin_warp_x;
    logic [NUM_PLUGINS*WARP_WIDTH-1:0] plugin_warp_y;
    logic [NUM_PLUGINS*WARP_WIDTH-1:0] plugin_warp_z;
    logic [NUM_PLUGINS*ERROR_WIDTH-1:0] plugin_error;
    logic                              done;
    logic                              timeout;
    logic [NUM_PLUGINS-1:0]            valid_mask;
    logic                              sel_valid;
    logic [SEL_W-1:0]                  sel_id;
    logic [WARP_WIDTH-1:0]             sel_warp_x;
    logic [WARP_WIDTH-1:0]             sel_warp_y;
    logic [WARP_WIDTH-1:0]             sel_warp_z;
    logic [ERROR_WIDTH-1:0]            sel_error;

    modport master (
        output req, plugin_valid, plugin_warp_x, plugin_warp_y, plugin_warp_z, plugin_error,
        input  busy, plugin_start, done, timeout, valid_mask,
               sel_valid, sel_id, sel_warp_x, sel_warp_y, sel_warp_z, sel_error
    );

    modport slave (
        input  req, plugin_valid, plugin_warp_x, plugin_warp_y, plugin_warp_z, plugin_error,
        output busy, plugin_start, done, timeout, valid_mask,
               sel_valid, sel_id, sel_warp_x, sel_warp_y, sel_warp_z, sel_error
    );

endinterface
`default_nettype wire

// File: rtl/plugin_min_select.sv
`default_nettype none
// ============================================================================
// Module   : plugin_min_select
// Brief    : Registered running-minimum stage; replaces only on strictly-less
// Revision : 1.0
// ============================================================================
module plugin_min_select import plugin_collector_pkg::*; #(
    parameter int NUM_PLUGINS = c_def_num_plugins,
    parameter int WARP_WIDTH  = c_def_warp_width,
    parameter int ERROR_WIDTH = c_def_error_width,
    parameter int SEL_W       = sel_width(NUM_PLUGINS)
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   i_clear,
    input  wire logic                   i_cand_en,
    input  wire logic [SEL_W-1:0]       i_cand_id,
    input  wire logic [WARP_WIDTH-1:0]  i_cand_x,
    input  wire logic [WARP_WIDTH-1:0]  i_cand_y,
    input  wire logic [WARP_WIDTH-1:0]  i_cand_z,
    input  wire logic [ERROR_WIDTH-1:0] i_cand_err,
    output logic                        o_sel_valid,
    output logic [SEL_W-1:0]            o_sel_id,
    output logic [WARP_WIDTH-1:0]       o_sel_x,
    output logic [WARP_WIDTH-1:0]       o_sel_y,
    output logic [WARP_WIDTH-1:0]       o_sel_z,
    output logic [ERROR_WIDTH-1:0]      o_sel_err
);

    logic w_take;
    assign w_take = i_cand_en && (!o_sel_valid || (i_cand_err < o_sel_err));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sel_valid <= 1'b0;
            o_sel_id    <= '0;
            o_sel_x     <= '0;
            o_sel_y     <= '0;
            o_sel_z     <= '0;
            o_sel_err   <= '0;
        end else if (i_clear) begin
            o_sel_valid <= 1'b0;
            o_sel_id    <= '0;
            o_sel_x     <= '0;
            o_sel_y     <= '0;
            o_sel_z     <= '0;
            o_sel_err   <= '0;
        end else if (w_take) begin
            o_sel_valid <= 1'b1;
            o_sel_id    <= i_cand_id;
            o_sel_x     <= i_cand_x;
            o_sel_y     <= i_cand_y;
            o_sel_z     <= i_cand_z;
            o_sel_err   <= i_cand_err;
        end
    end

endmodule
`default_nettype wire

// File: rtl/plugin_collector.sv
`default_nettype none
// ============================================================================
// Module   : plugin_collector
// Brief    : Starts all plugins, collects their results, picks the min-error one
// Revision : 1.0
// ============================================================================
module plugin_collector import plugin_collector_pkg::*; #(
    parameter int NUM_PLUGINS    = c_def_num_plugins,
    parameter int WARP_WIDTH     = c_def_warp_width,
    parameter int ERROR_WIDTH    = c_def_error_width,
    parameter int TIMEOUT_CYCLES = c_def_timeout_cycles
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    plugin_collector_if.slave bus
);

    localparam int SEL_W = sel_width(NUM_PLUGINS);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SEL_W-1:0] c_scan_last = SEL_W'(NUM_PLUGINS - 1);

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [CNT_W-1:0]       r_count;
    logic [SEL_W-1:0]       r_scan;
    logic                   r_timeout;
    logic [NUM_PLUGINS-1:0] r_valid_mask;
    logic                   w_all_valid;
    logic                   w_collect_exit;
    logic                   w_cand_en;

    assign w_all_valid    = &bus.plugin_valid;
    assign w_collect_exit = (r_state == c_st_collect) && (w_all_valid || (r_count == c_cnt_last));
    assign w_cand_en      = (r_state == c_st_select) && r_valid_mask[r_scan];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    if (bus.req) w_state_nxt = c_st_start;
            c_st_start:   w_state_nxt = c_st_collect;
            c_st_collect: if (w_collect_exit) w_state_nxt = c_st_select;
            c_st_select:  if (r_scan == c_scan_last) w_state_nxt = c_st_done;
            c_st_done:    w_state_nxt = c_st_idle;
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_count      <= '0;
            r_scan       <= '0;
            r_timeout    <= 1'b0;
            r_valid_mask <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_start) begin
                r_count <= '0;
            end else if ((r_state == c_st_collect) && !w_collect_exit) begin
                r_count <= r_count + 1'b1;
            end
            // The valid snapshot and scan restart land on the same edge as SELECT entry.
            if (w_collect_exit) begin
                r_valid_mask <= bus.plugin_valid;
                r_timeout    <= ~w_all_valid;
                r_scan       <= '0;
            end else if (r_state == c_st_select) begin
                r_scan <= r_scan + 1'b1;
            end
        end
    end

    logic                   w_sel_valid;
    logic [SEL_W-1:0]       w_sel_id;
    logic [WARP_WIDTH-1:0]  w_sel_x;
    logic [WARP_WIDTH-1:0]  w_sel_y;
    logic [WARP_WIDTH-1:0]  w_sel_z;
    logic [ERROR_WIDTH-1:0] w_sel_err;

    plugin_min_select #(
        .NUM_PLUGINS (NUM_PLUGINS),
        .WARP_WIDTH  (WARP_WIDTH),
        .ERROR_WIDTH (ERROR_WIDTH),
        .SEL_W       (SEL_W)
    ) u_min_select (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_collect_exit),
        .i_cand_en   (w_cand_en),
        .i_cand_id   (r_scan),
        .i_cand_x    (bus.plugin_warp_x[r_scan*WARP_WIDTH +: WARP_WIDTH]),
        .i_cand_y    (bus.plugin_warp_y[r_scan*WARP_WIDTH +: WARP_WIDTH]),
        .i_cand_z    (bus.plugin_warp_z[r_scan*WARP_WIDTH +: WARP_WIDTH]),
        .i_cand_err  (bus.plugin_error[r_scan*ERROR_WIDTH +: ERROR_WIDTH]),
        .o_sel_valid (w_sel_valid),
        .o_sel_id    (w_sel_id),
        .o_sel_x     (w_sel_x),
        .o_sel_y     (w_sel_y),
        .o_sel_z     (w_sel_z),
        .o_sel_err   (w_sel_err)
    );

    assign bus.busy         = (r_state != c_st_idle);
    assign bus.plugin_start = (r_state == c_st_start);
    assign bus.done         = (r_state == c_st_done);
    assign bus.timeout      = r_timeout;
    assign bus.valid_mask   = r_valid_mask;
    assign bus.sel_valid    = w_sel_valid;
    assign bus.sel_id       = w_sel_id;
    assign bus.sel_warp_x   = w_sel_x;
    assign bus.sel_warp_y   = w_sel_y;
    assign bus.sel_warp_z   = w_sel_z;
    assign bus.sel_error    = w_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_plugin_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_plugin_collector
// Brief    : Randomized and directed rounds against a per-round result model
// Revision : 1.0
// ============================================================================
module tb_plugin_collector;
    import plugin_collector_pkg::*;

    localparam int NP    = 4;
    localparam int WW    = 16;
    localparam int EW    = 32;
    localparam int TO    = 64;
    localparam int NEVER = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    plugin_collector_if #(.NUM_PLUGINS(NP), .WARP_WIDTH(WW), .ERROR_WIDTH(EW)) bus ();

    plugin_collector #(
        .NUM_PLUGINS(NP), .WARP_WIDTH(WW), .ERROR_WIDTH(EW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-slot stimulus: slot i turns valid dly[i] cycles into COLLECT (negative = already valid).
    int            dly [NP];
    logic [EW-1:0] err [NP];
    logic [WW-1:0] wx  [NP];
    logic [WW-1:0] wy  [NP];
    logic [WW-1:0] wz  [NP];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},       64'(bus.busy), 0);
        check({tag, ".start"},      64'(bus.plugin_start), 0);
        check({tag, ".done"},       64'(bus.done), 0);
        check({tag, ".timeout"},    64'(bus.timeout), 0);
        check({tag, ".valid_mask"}, 64'(bus.valid_mask), 0);
        check({tag, ".sel_valid"},  64'(bus.sel_valid), 0);
        check({tag, ".sel_id"},     64'(bus.sel_id), 0);
        check({tag, ".sel_warp"},   {16'h0, bus.sel_warp_x, bus.sel_warp_y, bus.sel_warp_z}, 0);
        check({tag, ".sel_error"},  64'(bus.sel_error), 0);
    endtask

    // t counts cycles from the cycle in which req is first presented.
    task automatic drive(input int t, input bit req);
        bus.req = req;
        for (int i = 0; i < NP; i++) begin
            bus.plugin_valid[i]             = (t >= 2 + dly[i]);
            bus.plugin_warp_x[i*WW +: WW]   = wx[i];
            bus.plugin_warp_y[i*WW +: WW]   = wy[i];
            bus.plugin_warp_z[i*WW +: WW]   = wz[i];
            bus.plugin_error[i*EW +: EW]    = err[i];
        end
    endtask

    task automatic run_round(input bit hold, input string tag, output int done_t);
        int            c_len;
        int            latest;
        bit            all_fin;
        logic [NP-1:0] mask;
        logic [EW-1:0] min_err;
        int            best;
        int            starts;
        int            dones;
        int            done_at;

        // Window length: ends when the last slot turns valid, capped at the timeout.
        all_fin = 1'b1;
        latest  = 0;
        for (int i = 0; i < NP; i++) begin
            if (dly[i] >= NEVER) all_fin = 1'b0;
            else if (dly[i] > latest) latest = dly[i];
        end
        c_len = (all_fin && (latest + 1 <= TO)) ? latest + 1 : TO;
        for (int i = 0; i < NP; i++) mask[i] = (dly[i] <= c_len - 1);

        // Winner: smallest error among captured slots, first index holding it.
        best    = -1;
        min_err = '1;
        for (int i = 0; i < NP; i++) if (mask[i] && err[i] <= min_err) min_err = err[i];
        for (int i = NP - 1; i >= 0; i--) if (mask[i] && err[i] == min_err) best = i;

        done_t  = 1 + c_len + NP + 1;
        starts  = 0;
        dones   = 0;
        done_at = -1;
        for (int t = 0; t <= done_t; t++) begin
            @(negedge clk);
            if (bus.plugin_start) starts++;
            if (bus.done) begin dones++; done_at = t; end
            if (t == 1) check({tag, ".busy_start"}, 64'(bus.busy), 1);
            if (t == done_t) begin
                check({tag, ".timeout"},    64'(bus.timeout), 64'(mask != '1));
                check({tag, ".valid_mask"}, 64'(bus.valid_mask), 64'(mask));
                check({tag, ".sel_valid"},  64'(bus.sel_valid), 64'(best >= 0));
                check({tag, ".sel_id"},     64'(bus.sel_id), (best >= 0) ? 64'(best) : 0);
                check({tag, ".sel_error"},  64'(bus.sel_error), (best >= 0) ? 64'(err[best]) : 0);
                check({tag, ".sel_warp"},   {16'h0, bus.sel_warp_x, bus.sel_warp_y, bus.sel_warp_z},
                      (best >= 0) ? {16'h0, wx[best], wy[best], wz[best]} : 64'h0);
            end
            drive(t, (t == 0) || hold);
        end
        check({tag, ".done_cycle"}, 64'(done_at), 64'(done_t));
        check({tag, ".done_count"}, 64'(dones), 1);
        check({tag, ".start_count"}, 64'(starts), 1);
    endtask

    task automatic set_slots(input int d0, d1, d2, d3, input logic [EW-1:0] e0, e1, e2, e3);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
        err[0] = e0; err[1] = e1; err[2] = e2; err[3] = e3;
        for (int i = 0; i < NP; i++) begin
            wx[i] = WW'(i);
            wy[i] = WW'(i);
            wz[i] = WW'(i);
        end
    endtask

    initial begin
        int done_t;
        int cnt;
        bit seen;

        set_slots(NEVER, NEVER, NEVER, NEVER, 0, 0, 0, 0);
        drive(0, 1'b0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // All errors equal, valids already high before the request.
        set_slots(-2, -2, -2, -2, 1, 1, 1, 1);
        run_round(1'b0, "all_equal", done_t);

        set_slots(0, 0, 0, 0, 5, 3, 3, 9);
        run_round(1'b0, "tie_low_index", done_t);

        // Reset in the middle of COLLECT aborts the round.
        set_slots(NEVER, NEVER, NEVER, NEVER, 2, 2, 2, 2);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            drive(t, t == 0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (TO + 20) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("mid_reset.no_done", 64'(seen), 0);
        set_slots(1, 0, 2, 0, 7, 4, 6, 8);
        run_round(1'b0, "after_reset", done_t);

        set_slots(0, 0, NEVER, 0, 1, 1, 0, 1);
        run_round(1'b0, "slot2_missing", done_t);

        set_slots(NEVER, NEVER, NEVER, NEVER, 1, 2, 3, 4);
        run_round(1'b0, "none_valid", done_t);

        // req held high: next round begins only after returning to IDLE.
        set_slots(0, 1, 0, 2, 3, 1, 2, 1);
        run_round(1'b1, "req_held", done_t);
        @(negedge clk);
        check("req_held.idle_busy", 64'(bus.busy), 0);
        check("req_held.idle_start", 64'(bus.plugin_start), 0);
        drive(done_t + 1, 1'b1);
        @(negedge clk);
        check("req_held.restart", 64'(bus.plugin_start), 1);
        drive(0, 1'b0);
        cnt = 0;
        while (bus.busy && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("req_held.drain", 64'(bus.busy), 0);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < NP; i++) begin
                case ($urandom_range(0, 5))
                    0:       dly[i] = NEVER;
                    1:       dly[i] = int'($urandom_range(0, 80));
                    default: dly[i] = int'($urandom_range(0, 10)) - 2;
                endcase
                err[i] = EW'($urandom_range(0, 3));
                wx[i]  = WW'($urandom);
                wy[i]  = WW'($urandom);
                wz[i]  = WW'($urandom);
            end
            run_round(1'b0, "random", done_t);
            drive(0, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plugin_collector.md
PLUGIN_COLLECTOR -- requirements
Module: plugin_collector

Interface
REQ-001 SHALL have parameters: NUM_PLUGINS, default 4, number of plugin slots; WARP_WIDTH, default 16, warp component width; ERROR_WIDTH, default 32, error width; TIMEOUT_CYCLES, default 64, maximum COLLECT window length in cycles.
REQ-002 SHALL have ports, one per line:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
req  in  1  request one collection round; sampled only in IDLE
busy  out  1  high in every state except IDLE
plugin_start  out  1  one-cycle start pulse, broadcast to all plugins
plugin_valid  in  NUM_PLUGINS  per-plugin valid, level-sensitive
plugin_warp_x  in  NUM_PLUGINS*WARP_WIDTH  packed warp X, slot i at bits [i*WARP_WIDTH +: WARP_WIDTH]
plugin_warp_y  in  NUM_PLUGINS*WARP_WIDTH  packed warp Y, same packing
plugin_warp_z  in  NUM_PLUGINS*WARP_WIDTH  packed warp Z, same packing
plugin_error  in  NUM_PLUGINS*ERROR_WIDTH  packed error, slot i at bits [i*ERROR_WIDTH +: ERROR_WIDTH]
done  out  1  one-cycle pulse when results are valid
timeout  out  1  result flag: the COLLECT window expired before all plugins were valid
valid_mask  out  NUM_PLUGINS  plugin_valid captured at COLLECT exit
sel_valid  out  1  at least one plugin was selected
sel_id  out  clog2(NUM_PLUGINS), minimum 1  index of the selected plugin
sel_warp_x/y/z  out  WARP_WIDTH each  warp of the selected plugin
sel_error  out  ERROR_WIDTH  error of the selected plugin

Function
REQ-003 SHALL implement the states IDLE, START, COLLECT, SELECT and DONE.
REQ-004 SHALL go IDLE->START on the first cycle req=1 in IDLE; req in any other state is ignored and not queued.
REQ-005 SHALL assert plugin_start for exactly the one START cycle, then go to COLLECT.
REQ-006 SHALL, in COLLECT, count cycles from 0 and exit to SELECT when &plugin_valid=1 or when count==TIMEOUT_CYCLES-1, whichever comes first.
REQ-007 SHALL, on COLLECT exit, capture valid_mask<=plugin_valid and set timeout<=~&plugin_valid.
REQ-008 SHALL sample plugin data only while scanning in SELECT; plugins hold their outputs stable for the whole round.
REQ-009 SHALL, in SELECT, scan slots 0..NUM_PLUGINS-1, one slot per cycle (NUM_PLUGINS cycles), considering only slots with their valid_mask bit set.
REQ-010 SHALL select the minimum error using an unsigned compare; on a tie the lowest index wins, so replacement requires strictly-less.
REQ-011 SHALL, if no slot is valid, leave sel_valid=0 and sel_id, sel_warp_x/y/z and sel_error at 0.
REQ-012 SHALL clear sel_* to 0 on entry to SELECT, so no stale results survive from a previous round.
REQ-013 SHALL go SELECT->DONE, pulse done for exactly one cycle, then go to IDLE; all result outputs hold until the next SELECT entry.
REQ-014 SHALL give a latency from req to done of 1(START)+C(COLLECT)+NUM_PLUGINS(SELECT)+1, with C in 1..TIMEOUT_CYCLES.
REQ-015 SHALL exit COLLECT on the first COLLECT cycle (C=1) when plugin_valid is already all-ones; this includes sticky valids from a previous round.

Reset
REQ-016 SHALL, under rst_n=0, force state=IDLE, the counter to 0, and every output to 0 (busy, plugin_start, done, timeout, valid_mask, sel_*).
REQ-017 SHALL abort a round on reset in any state with no done pulse; req is honoured from the first clock after deassertion.

Structure
REQ-018 SHALL place the state encoding and default parameter constants in a shared plugin package, shared with the plugin modules.
REQ-019 SHALL use one sub-module, plugin_min_select: a registered compare/replace stage for the running minimum, used by SELECT.

Verification
REQ-020 SHALL check: 4 plugins with IDs 0..3 and all errors 1, req -> C=1, sel_id=0, sel_warp=0/0/0, sel_error=1, timeout=0, done at cycle 7.
REQ-021 SHALL check: errors 5,3,3,9, all valid -> sel_id=1, sel_error=3 (tie resolved to lowest index).
REQ-022 SHALL check: slot 2 never valid, errors 1,1,0,1 -> done at cycle 70, timeout=1, valid_mask=4'b1011, sel_id=0.
REQ-023 SHALL check: no plugin valid -> timeout=1, valid_mask=0, sel_valid=0, all sel_* = 0.
REQ-024 SHALL check: rst_n pulsed mid-COLLECT -> all outputs 0, no done; a new req afterwards completes normally.
REQ-025 SHALL check: req held high through a round -> the next round starts only after DONE->IDLE, with exactly one plugin_start per round.
